// File: rtl/uart_char_fifo.sv
// Character FIFO for a UART datapath: a circular buffer with count, sticky
// overflow/underflow flags and a hex display of the most recently accepted characters.
module uart_char_fifo #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 8,
    parameter int DISP_DIGITS = 4,
    localparam int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_wr_valid,
    input  logic [DATA_W-1:0]        i_wr_data,
    input  logic                     i_rd_en,
    input  logic                     i_clr,
    output logic [DATA_W-1:0]        o_rd_data,
    output logic                     o_rd_valid,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [CNT_W-1:0]         o_count,
    output logic                     o_ovf,
    output logic                     o_udf,
    output logic [4*DISP_DIGITS-1:0] o_disp
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int DISP_W = 4 * DISP_DIGITS;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // ASCII hex digit to nibble; only the 7-bit code is considered.
    function automatic logic [3:0] f_hex_decode(input logic [6:0] i_c);
        logic [3:0] w_nib;
        w_nib = 4'd0;
        if (i_c >= 7'h30 && i_c <= 7'h39)
            w_nib = i_c[3:0];
        else if ((i_c >= 7'h41 && i_c <= 7'h46) || (i_c >= 7'h61 && i_c <= 7'h66))
            w_nib = i_c[3:0] + 4'd9;
        return w_nib;
    endfunction

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_ovf;
    logic              r_udf;
    logic [DISP_W-1:0] r_disp;

    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_rd_acc;
    logic w_wr_drop;
    logic w_rd_under;
    logic [3:0] w_nib;

    assign w_full     = (r_count == FULL_CNT);
    assign w_empty    = (r_count == '0);
    // A write into a full buffer still fits when the same edge retires the oldest entry.
    assign w_wr_acc   = i_wr_valid && (!w_full || i_rd_en);
    assign w_rd_acc   = i_rd_en && !w_empty;
    assign w_wr_drop  = i_wr_valid && w_full && !i_rd_en;
    assign w_rd_under = i_rd_en && w_empty;
    assign w_nib      = f_hex_decode(i_wr_data[6:0]);

    // Storage is not reset; pointers and count define which entries are live.
    always_ff @(posedge i_clk) begin
        if (i_rstn && !i_clr && w_wr_acc)
            r_mem[r_wr_ptr] <= i_wr_data;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
            r_disp     <= '0;
        end else if (i_clr) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
            r_disp     <= '0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
            end
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                r_disp   <= (r_disp << 4) | DISP_W'(w_nib);
            end
            if (w_wr_drop)
                r_ovf <= 1'b1;
            if (w_rd_under)
                r_udf <= 1'b1;
            if (w_wr_acc && !w_rd_acc)
                r_count <= r_count + CNT_W'(1);
            else if (w_rd_acc && !w_wr_acc)
                r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_count    = r_count;
    assign o_ovf      = r_ovf;
    assign o_udf      = r_udf;
    assign o_disp     = r_disp;

endmodule

// File: tb/tb_uart_char_fifo.sv
// Bench for uart_char_fifo: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_uart_char_fifo;

    localparam int DATA_W      = 8;
    localparam int DEPTH       = 4;
    localparam int DISP_DIGITS = 4;
    localparam int CNT_W       = $clog2(DEPTH) + 1;

    logic              i_clk = 1'b0;
    logic              i_rstn;
    logic              i_wr_valid;
    logic [DATA_W-1:0] i_wr_data;
    logic              i_rd_en;
    logic              i_clr;
    logic [DATA_W-1:0] o_rd_data;
    logic              o_rd_valid;
    logic              o_full;
    logic              o_empty;
    logic [CNT_W-1:0]  o_count;
    logic              o_ovf;
    logic              o_udf;
    logic [15:0]       o_disp;

    uart_char_fifo #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .DISP_DIGITS (DISP_DIGITS)
    ) dut (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_wr_valid (i_wr_valid),
        .i_wr_data  (i_wr_data),
        .i_rd_en    (i_rd_en),
        .i_clr      (i_clr),
        .o_rd_data  (o_rd_data),
        .o_rd_valid (o_rd_valid),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_count    (o_count),
        .o_ovf      (o_ovf),
        .o_udf      (o_udf),
        .o_disp     (o_disp)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [7:0]  m_q [$];
    logic        m_ovf;
    logic        m_udf;
    logic        m_rd_valid;
    logic [7:0]  m_rd_data;
    logic [15:0] m_disp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int hexval(input logic [7:0] c);
        int a;
        a = int'(c & 8'h7F);
        if (a >= 48 && a <= 57)  return a - 48;
        if (a >= 65 && a <= 70)  return a - 65 + 10;
        if (a >= 97 && a <= 102) return a - 97 + 10;
        return 0;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ovf      = 1'b0;
        m_udf      = 1'b0;
        m_rd_valid = 1'b0;
        m_rd_data  = 8'h00;
        m_disp     = 16'h0000;
    endtask

    task automatic model_update(input bit wr, input logic [7:0] d, input bit rd, input bit clr);
        bit full, empty, rd_ok, wr_ok;
        if (clr) begin
            m_q.delete();
            m_ovf      = 1'b0;
            m_udf      = 1'b0;
            m_disp     = 16'h0000;
            m_rd_valid = 1'b0;
            return;
        end
        full  = (m_q.size() == DEPTH);
        empty = (m_q.size() == 0);
        rd_ok = rd && !empty;
        wr_ok = wr && (!full || rd);
        m_rd_valid = rd_ok;
        if (rd_ok) m_rd_data = m_q.pop_front();
        if (rd && empty) m_udf = 1'b1;
        if (wr && !wr_ok) m_ovf = 1'b1;
        if (wr_ok) begin
            m_q.push_back(d);
            m_disp = 16'((int'(m_disp) * 16 + hexval(d)) % 65536);
        end
    endtask

    always @(negedge i_clk) begin
        if (chk_en) begin
            chk("count",    32'(o_count),    32'(m_q.size()));
            chk("full",     32'(o_full),     32'(m_q.size() == DEPTH));
            chk("empty",    32'(o_empty),    32'(m_q.size() == 0));
            chk("ovf",      32'(o_ovf),      32'(m_ovf));
            chk("udf",      32'(o_udf),      32'(m_udf));
            chk("disp",     32'(o_disp),     32'(m_disp));
            chk("rd_valid", 32'(o_rd_valid), 32'(m_rd_valid));
            chk("rd_data",  32'(o_rd_data),  32'(m_rd_data));
        end
    end

    task automatic step(input bit wr, input logic [7:0] d, input bit rd, input bit clr);
        i_wr_valid = wr;
        i_wr_data  = d;
        i_rd_en    = rd;
        i_clr      = clr;
        @(posedge i_clk);
        model_update(wr, d, rd, clr);
        #2;
        i_wr_valid = 1'b0;
        i_rd_en    = 1'b0;
        i_clr      = 1'b0;
    endtask

    task automatic fill_1234();
        step(1, "1", 0, 0);
        step(1, "2", 0, 0);
        step(1, "3", 0, 0);
        step(1, "4", 0, 0);
    endtask

    logic [7:0] seq [12];

    initial begin
        seq = '{"A", "b", "0", "9", "@", "G", 8'hB1, "f", "c", "E", "z", "5"};
        i_rstn = 1'b0; i_wr_valid = 1'b0; i_wr_data = 8'h00; i_rd_en = 1'b0; i_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge i_clk);
        #2;
        chk("rst_empty",    32'(o_empty),    32'd1);
        chk("rst_full",     32'(o_full),     32'd0);
        chk("rst_count",    32'(o_count),    32'd0);
        chk("rst_disp",     32'(o_disp),     32'd0);
        chk("rst_rd_valid", 32'(o_rd_valid), 32'd0);
        chk("rst_rd_data",  32'(o_rd_data),  32'd0);
        i_rstn = 1'b1;
        chk_en = 1'b1;

        // Fill and drain in order
        fill_1234();
        chk("fill_full",  32'(o_full),  32'd1);
        chk("fill_count", 32'(o_count), 32'd4);
        chk("fill_disp",  32'(o_disp),  32'h1234);
        for (int k = 0; k < 4; k++) begin
            step(0, 8'h00, 1, 0);
            chk("drain_data",  32'(o_rd_data),  32'(8'h31 + k));
            chk("drain_valid", 32'(o_rd_valid), 32'd1);
        end
        step(0, 8'h00, 0, 0);
        chk("drain_empty", 32'(o_empty),    32'd1);
        chk("drain_novld", 32'(o_rd_valid), 32'd0);

        // Overflow on full
        fill_1234();
        step(1, "a", 0, 0);
        chk("ovf_flag",  32'(o_ovf),   32'd1);
        chk("ovf_disp",  32'(o_disp),  32'h1234);
        chk("ovf_count", 32'(o_count), 32'd4);
        for (int k = 0; k < 4; k++) begin
            step(0, 8'h00, 1, 0);
            chk("ovf_rd", 32'(o_rd_data), 32'(8'h31 + k));
        end
        chk("ovf_sticky", 32'(o_ovf), 32'd1);
        step(0, 8'h00, 0, 1);
        chk("clr_ovf",  32'(o_ovf),  32'd0);
        chk("clr_disp", 32'(o_disp), 32'd0);

        // Simultaneous write and read while full
        fill_1234();
        step(1, "F", 1, 0);
        chk("wr_rd_full_data",  32'(o_rd_data), 32'h31);
        chk("wr_rd_full_count", 32'(o_count),   32'd4);
        chk("wr_rd_full_disp",  32'(o_disp),    32'h234F);
        for (int k = 0; k < 4; k++) begin
            step(0, 8'h00, 1, 0);
            chk("wr_rd_full_rd", 32'(o_rd_data), (k == 3) ? 32'h46 : 32'(8'h32 + k));
        end

        // Simultaneous write and read while empty
        step(1, "x", 1, 0);
        chk("udf_flag",  32'(o_udf),      32'd1);
        chk("udf_novld", 32'(o_rd_valid), 32'd0);
        chk("udf_count", 32'(o_count),    32'd1);
        chk("udf_disp",  32'(o_disp),     32'h34F0);
        chk("udf_hold",  32'(o_rd_data),  32'h46);
        step(0, 8'h00, 1, 0);
        chk("udf_next", 32'(o_rd_data), 32'h78);

        // Clear wins over same-cycle read and write
        step(1, "7", 0, 0);
        step(1, "8", 1, 1);
        chk("clrpri_count", 32'(o_count),    32'd0);
        chk("clrpri_vld",   32'(o_rd_valid), 32'd0);
        chk("clrpri_data",  32'(o_rd_data),  32'h78);
        chk("clrpri_udf",   32'(o_udf),      32'd0);

        // Two-deep streaming across several pointer wraps
        step(1, seq[0], 0, 0);
        step(1, seq[1], 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, seq[i+2], 1, 0);
            chk("wrap_data",  32'(o_rd_data), 32'(seq[i]));
            chk("wrap_count", 32'(o_count),   32'd2);
        end
        step(0, 8'h00, 1, 0);
        chk("wrap_tail0", 32'(o_rd_data), 32'(seq[10]));
        step(0, 8'h00, 1, 0);
        chk("wrap_tail1", 32'(o_rd_data), 32'(seq[11]));
        chk("wrap_disp",  32'(o_disp),    32'hCE05);

        // Asynchronous reset with entries held and overflow set
        fill_1234();
        step(1, "5", 0, 0);
        step(0, 8'h00, 1, 0);
        chk("prerst_count", 32'(o_count), 32'd3);
        chk("prerst_ovf",   32'(o_ovf),   32'd1);
        i_rstn = 1'b0;
        model_reset();
        #1;
        chk("arst_count", 32'(o_count),    32'd0);
        chk("arst_empty", 32'(o_empty),    32'd1);
        chk("arst_ovf",   32'(o_ovf),      32'd0);
        chk("arst_disp",  32'(o_disp),     32'd0);
        chk("arst_data",  32'(o_rd_data),  32'd0);
        chk("arst_vld",   32'(o_rd_valid), 32'd0);
        @(posedge i_clk);
        @(posedge i_clk);
        #2;
        i_rstn = 1'b1;
        step(1, "9", 0, 0);
        chk("postrst_count", 32'(o_count), 32'd1);
        chk("postrst_disp",  32'(o_disp),  32'h0009);
        step(0, 8'h00, 1, 0);
        chk("postrst_data", 32'(o_rd_data), 32'h39);

        step(0, 8'h00, 0, 0);
        @(negedge i_clk);
        chk_en = 1'b0;
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
